// File: rtl/i2c_exp_pkg.sv
// Shared types and constants for the I2C GPIO-expander responder:
// register map, reset values and responder state encoding.
package i2c_exp_pkg;

    typedef enum logic [1:0] {
        REG_IN  = 2'd0,
        REG_OUT = 2'd1,
        REG_POL = 2'd2,
        REG_CFG = 2'd3
    } reg_idx_e;

    localparam logic [7:0] OUT_RST = 8'hFF;
    localparam logic [7:0] POL_RST = 8'h00;
    localparam logic [7:0] CFG_RST = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } resp_state_e;

    // Register 0 reads the pins through the polarity mask.
    function automatic logic [7:0] reg_read(
        input logic [1:0] idx,
        input logic [7:0] pins,
        input logic [7:0] out_val,
        input logic [7:0] pol_val,
        input logic [7:0] cfg_val
    );
        logic [7:0] val;
        case (idx)
            REG_IN:  val = pins ^ pol_val;
            REG_OUT: val = out_val;
            REG_POL: val = pol_val;
            default: val = cfg_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock and produces one-cycle
// SCL edge and START/STOP event pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_level
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s, sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Reset to the idle-bus level so leaving reset never fakes an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start     = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop      = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign sda_level = sda_s;

endmodule

// File: rtl/i2c_expander_responder.sv
// I2C target emulating an 8-bit GPIO expander (input, output, polarity and
// configuration registers) with open-drain SDA and a pin-change interrupt.
module i2c_expander_responder
    import i2c_exp_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic [7:0] gpio_dir,
    output logic       int_n,
    output logic       wr_strobe
);

    logic scl_rise, scl_fall, bus_start, bus_stop, sda_level;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (bus_start),
        .stop     (bus_stop),
        .sda_level(sda_level)
    );

    resp_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        rw_q, rw_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  out_q, out_d;
    logic [7:0]  pol_q, pol_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [7:0]  cap_q, cap_d;
    logic        int_n_q, int_n_d;
    logic        oe_q, oe_d;
    logic        wr_strobe_q, wr_strobe_d;

    logic [7:0]  shifted;
    logic [7:0]  rd_val;

    assign shifted = {sh_q[6:0], sda_level};
    assign rd_val  = reg_read(ptr_q, gpio_in, out_q, pol_q, cfg_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        out_d       = out_q;
        pol_d       = pol_q;
        cfg_d       = cfg_q;
        cap_d       = cap_q;
        oe_d        = oe_q;
        wr_strobe_d = 1'b0;

        if (bus_start) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (bus_stop) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (shifted[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = shifted[0];
                                if (shifted[0]) begin
                                    sh_d = rd_val;
                                    if (ptr_q == REG_IN) begin
                                        cap_d = gpio_in;
                                    end
                                end
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_PTR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == ST_PTR) begin
                                ptr_d   = shifted[1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                wr_strobe_d = 1'b1;
                                state_d     = ST_WR_ACK;
                                case (ptr_q)
                                    REG_OUT: out_d = shifted;
                                    REG_POL: pol_d = shifted;
                                    REG_CFG: cfg_d = shifted;
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                // First fall after the 8th bit opens the ACK, the next one closes it.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = 4'd0;
                            if (state_q == ST_ADDR_ACK) begin
                                if (rw_q) begin
                                    state_d = ST_RD_DATA;
                                    oe_d    = ~sh_q[7];
                                end else begin
                                    state_d = ST_PTR;
                                end
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = ST_RD_ACK;
                            oe_d    = 1'b0;
                        end else begin
                            sh_d = {sh_q[6:0], 1'b0};
                            oe_d = ~sh_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_level) begin
                            state_d = ST_IGNORE;
                        end else begin
                            sh_d = rd_val;
                        end
                    end else if (scl_fall) begin
                        state_d = ST_RD_DATA;
                        cnt_d   = 4'd0;
                        oe_d    = ~sh_q[7];
                    end
                end
                default: ;
            endcase
        end

        // Uses the next capture so the clear lands in the capture cycle itself.
        int_n_d = ~|((gpio_in ^ cap_d) & cfg_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            sh_q        <= 8'h00;
            rw_q        <= 1'b0;
            ptr_q       <= 2'd0;
            out_q       <= OUT_RST;
            pol_q       <= POL_RST;
            cfg_q       <= CFG_RST;
            cap_q       <= gpio_in;
            int_n_q     <= 1'b1;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            pol_q       <= pol_d;
            cfg_q       <= cfg_d;
            cap_q       <= cap_d;
            int_n_q     <= int_n_d;
            oe_q        <= oe_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    assign sda_oe    = oe_q;
    assign gpio_out  = out_q;
    assign gpio_dir  = cfg_q;
    assign int_n     = int_n_q;
    assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_i2c_expander_responder.sv
// Directed bench for the I2C expander responder: a bit-banged master on a
// wired-AND SDA line exercises writes, reads, address mismatch, interrupt and reset.
module tb_i2c_expander_responder;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] gpio_in = 8'h00;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] gpio_out;
    logic [7:0] gpio_dir;
    logic       int_n;
    logic       wr_strobe;

    assign sda_line = sda_m & ~sda_oe;

    i2c_expander_responder #(
        .DEV_ADDR   (7'h20),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_dir (gpio_dir),
        .int_n    (int_n),
        .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         strobe_total = 0;
    int         oe_total = 0;
    int         viol_total = 0;
    logic [7:0] strobe_out_val = 8'h00;
    logic       oe_prev = 1'b0;
    logic       scl_prev = 1'b1;

    always @(posedge clk) begin
        if (wr_strobe) begin
            strobe_total++;
            strobe_out_val = gpio_out;
        end
        if (sda_oe) oe_total++;
        if (sda_oe !== oe_prev && scl_m && scl_prev) viol_total++;
        oe_prev  = sda_oe;
        scl_prev = scl_m;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        $display("  bus: STOP");
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic clock_ack(output logic ack);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = sda_line; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        clock_ack(ack);
        $display("  bus: write 0x%02h ack=%0b", b, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            scl_m = 1'b1; wait_q();
            d[i] = sda_line; wait_q();
            scl_m = 1'b0; wait_q();
        end
        send_bit(nack);
        $display("  bus: read 0x%02h master_%s", d, nack ? "nack" : "ack");
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; gpio_in = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (gpio_out !== 8'hFF) begin errors++; $display("FAIL reset_gpio_out: got %h expected ff", gpio_out); end
        checks++; if (gpio_dir !== 8'hFF) begin errors++; $display("FAIL reset_gpio_dir: got %h expected ff", gpio_dir); end
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n: got %b expected 1", int_n); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
    endtask

    task automatic test_write_out();
        logic a0, a1, a2;
        int   s0;
        s0 = strobe_total;
        i2c_start();
        write_byte(8'h40, a0);
        write_byte(8'h01, a1);
        write_byte(8'hA5, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL write_gpio_out: got %h expected a5", gpio_out); end
        checks++; if (strobe_total - s0 !== 1) begin errors++; $display("FAIL write_strobe_count: got %0d expected 1", strobe_total - s0); end
        checks++; if (strobe_out_val !== 8'hA5) begin errors++; $display("FAIL write_strobe_cycle_value: got %h expected a5", strobe_out_val); end
    endtask

    task automatic test_polarity_read();
        logic       a0, a1, a2, a3, a4;
        logic [7:0] d;
        i2c_start();
        write_byte(8'h40, a0);
        write_byte(8'h02, a1);
        write_byte(8'h0F, a2);
        i2c_stop();
        gpio_in = 8'h3C;
        repeat (4) @(negedge clk);
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL pol_int_low: got %b expected 0", int_n); end
        i2c_start();
        write_byte(8'h40, a3);
        write_byte(8'h00, a4);
        i2c_rstart();
        write_byte(8'h41, a0);
        read_byte(1'b1, d);
        checks++; if ({a1, a2, a3, a4, a0} !== 5'b00000) begin errors++; $display("FAIL pol_acks: got %b expected 00000", {a1, a2, a3, a4, a0}); end
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL pol_read_data: got %h expected 33", d); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL pol_released_before_stop: got %b expected 0", sda_oe); end
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL pol_int_cleared: got %b expected 1", int_n); end
        i2c_stop();
    endtask

    task automatic test_wrong_addr();
        logic a, b;
        int   s0, o0;
        s0 = strobe_total;
        o0 = oe_total;
        i2c_start();
        write_byte(8'h42, a);
        write_byte(8'h55, b);
        i2c_stop();
        checks++; if ({a, b} !== 2'b11) begin errors++; $display("FAIL wrong_addr_nack: got %b expected 11", {a, b}); end
        checks++; if (oe_total - o0 !== 0) begin errors++; $display("FAIL wrong_addr_sda_driven: got %0d cycles expected 0", oe_total - o0); end
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL wrong_addr_gpio_out: got %h expected a5", gpio_out); end
        checks++; if (strobe_total - s0 !== 0) begin errors++; $display("FAIL wrong_addr_strobe: got %0d expected 0", strobe_total - s0); end
    endtask

    task automatic test_read_cfg();
        logic       a0, a1, a2, a3, a4, a5;
        logic [7:0] d0, d1, d2, d3;
        i2c_start();
        write_byte(8'h40, a0);
        write_byte(8'h03, a1);
        i2c_rstart();
        write_byte(8'h41, a2);
        read_byte(1'b0, d0);
        read_byte(1'b0, d1);
        read_byte(1'b1, d2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL cfg_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if ({d0, d1, d2} !== 24'hFFFFFF) begin errors++; $display("FAIL cfg_burst: got %h expected ffffff", {d0, d1, d2}); end
        i2c_start();
        write_byte(8'h40, a3);
        write_byte(8'h02, a4);
        write_byte(8'h0F, a5);
        i2c_stop();
        i2c_start();
        write_byte(8'h40, a0);
        write_byte(8'h03, a1);
        i2c_rstart();
        write_byte(8'h41, a2);
        read_byte(1'b1, d3);
        i2c_stop();
        checks++; if (d3 !== 8'hFF) begin errors++; $display("FAIL cfg_after_pol_write: got %h expected ff", d3); end
    endtask

    task automatic test_int();
        logic       a0, a1, a2;
        logic [7:0] d;
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL int_idle: got %b expected 1", int_n); end
        gpio_in = 8'h2C;
        repeat (3) @(negedge clk);
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL int_on_toggle: got %b expected 0", int_n); end
        gpio_in = 8'h3C;
        repeat (3) @(negedge clk);
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL int_pin_restored: got %b expected 1", int_n); end
        gpio_in = 8'h2C;
        repeat (3) @(negedge clk);
        i2c_start();
        write_byte(8'h40, a0);
        write_byte(8'h00, a1);
        i2c_rstart();
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h41 >> i));
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL int_before_8th_rise: got %b expected 0", int_n); end
        send_bit(1'b1);
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL int_at_8th_rise: got %b expected 1", int_n); end
        clock_ack(a2);
        read_byte(1'b1, d);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL int_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (d !== 8'h23) begin errors++; $display("FAIL int_read_data: got %h expected 23", d); end
    endtask

    task automatic test_reset_mid();
        logic       a0, a1, a2;
        logic [7:0] d;
        int         s0, o0;
        i2c_start();
        write_byte(8'h40, a0);
        write_byte(8'h01, a1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("  bus: reset pulse mid-byte");
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_sda_oe: got %b expected 0", sda_oe); end
        checks++; if ({gpio_out, gpio_dir} !== 16'hFFFF) begin errors++; $display("FAIL rstmid_regs: got %h expected ffff", {gpio_out, gpio_dir}); end
        s0 = strobe_total;
        o0 = oe_total;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        clock_ack(a2);
        i2c_stop();
        checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL rstmid_no_ack: got %b expected 1", a2); end
        checks++; if (oe_total - o0 !== 0) begin errors++; $display("FAIL rstmid_sda_driven: got %0d cycles expected 0", oe_total - o0); end
        checks++; if (strobe_total - s0 !== 0 || gpio_out !== 8'hFF) begin errors++; $display("FAIL rstmid_ignored: got strobes %0d out %h expected 0 ff", strobe_total - s0, gpio_out); end
        i2c_start();
        write_byte(8'h40, a0);
        write_byte(8'h01, a1);
        write_byte(8'h12, a2);
        i2c_stop();
        checks++; if (gpio_out !== 8'h12) begin errors++; $display("FAIL rstmid_new_frame: got %h expected 12", gpio_out); end
        i2c_start();
        write_byte(8'h40, a0);
        write_byte(8'h00, a1);
        i2c_rstart();
        write_byte(8'h41, a2);
        read_byte(1'b1, d);
        i2c_stop();
        checks++; if (d !== 8'h2C) begin errors++; $display("FAIL rstmid_pol_cleared: got %h expected 2c", d); end
        checks++; if (viol_total !== 0) begin errors++; $display("FAIL sda_change_scl_high: got %0d expected 0", viol_total); end
    endtask

    initial begin
        test_reset();
        test_write_out();
        test_polarity_read();
        test_wrong_addr();
        test_read_cfg();
        test_int();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
